// File: rtl/window_3x3_generator_pkg.sv
// Shared definitions for the 3x3 window generator: pixel/kernel/counter
// widths and the frame-tracking FSM state type.
package window_3x3_generator_pkg;

  localparam int unsigned PIXEL_W = 8;
  localparam int unsigned KERNEL  = 3;
  localparam int unsigned CNT_W   = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/window_3x3_generator_row_shift.sv
// window_row_shift: KERNEL-stage PIXEL_W-bit enable shift register for one
// tap row. Parallel output byte c holds column c (0 = oldest).
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   en    in   shift in din this cycle
//   din   in   newest pixel of the row
//   taps  out  {c2, c1, c0}
module window_row_shift
  import window_3x3_generator_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [PIXEL_W-1:0]        din,
  output logic [KERNEL*PIXEL_W-1:0] taps
);

  // New pixel enters at the top byte; everything else moves one byte down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (en) begin
      taps <= {din, taps[KERNEL*PIXEL_W-1:PIXEL_W]};
    end
  end

endmodule

// File: rtl/window_3x3_generator.sv
// window_3x3_generator: builds a 3x3 pixel window from three line-buffer
// row taps, tracks column/row position and flags each complete window.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   valid_i  in   row0_i/row1_i/row2_i carry one valid column
//   row0_i   in   pixel from the oldest buffered row
//   row1_i   in   pixel from the middle row
//   row2_i   in   pixel from the newest row
//   window_o out  byte [8*(3r+c)+:8] = row r, col c (0 = oldest)
//   valid_o  out  window_o holds a complete window
//   done_o   out  pulse with the last window of the frame
//   busy_o   out  frame in progress (FILL or ACTIVE)
module window_3x3_generator
  import window_3x3_generator_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_i,
  input  logic [PIXEL_W-1:0]                row0_i,
  input  logic [PIXEL_W-1:0]                row1_i,
  input  logic [PIXEL_W-1:0]                row2_i,
  output logic [KERNEL*KERNEL*PIXEL_W-1:0]  window_o,
  output logic                              valid_o,
  output logic                              done_o,
  output logic                              busy_o
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(HEIGHT - 3);

  logic [PIXEL_W-1:0]        row_px [KERNEL];
  logic [KERNEL*PIXEL_W-1:0] taps   [KERNEL];

  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic             col_last;
  logic             row_last;
  state_t           state;
  state_t           state_nxt;

  always_comb begin
    row_px[0] = row0_i;
    row_px[1] = row1_i;
    row_px[2] = row2_i;
  end

  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    window_row_shift u_shift (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (valid_i),
      .din  (row_px[r]),
      .taps (taps[r])
    );
  end

  assign window_o = {taps[2], taps[1], taps[0]};
  assign col_last = (col_cnt == COL_LAST);
  assign row_last = (row_cnt == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (valid_i) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_last ? '0 : row_cnt + CNT_W'(1);
      end else begin
        col_cnt <= col_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (valid_i) state_nxt = FILL;
      FILL:    if (valid_i && col_cnt == CNT_W'(1)) state_nxt = ACTIVE;
      ACTIVE:  if (valid_i && col_last) state_nxt = row_last ? DONE : FILL;
      // A column arriving in DONE already starts the next frame.
      DONE:    state_nxt = valid_i ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done_o/busy_o are registered from the next state so they line up with
  // the registered state rather than the combinational transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_o <= valid_i && (col_cnt >= CNT_W'(2));
      done_o  <= (state_nxt == DONE);
      busy_o  <= (state_nxt == FILL) || (state_nxt == ACTIVE);
    end
  end

endmodule

// File: tb/tb_window_3x3_generator.sv
// Self-checking bench for window_3x3_generator with WIDTH=5, HEIGHT=4.
module tb_window_3x3_generator;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_i = 1'b0;
  logic [7:0]  row0_i = '0;
  logic [7:0]  row1_i = '0;
  logic [7:0]  row2_i = '0;
  logic [71:0] window_o;
  logic        valid_o;
  logic        done_o;
  logic        busy_o;

  window_3x3_generator #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .row0_i  (row0_i),
    .row1_i  (row1_i),
    .row2_i  (row2_i),
    .window_o(window_o),
    .valid_o (valid_o),
    .done_o  (done_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_win    = 0;
  int n_done   = 0;

  // Reference model state: position in the frame and the current row's columns.
  int         m_col  = 0;
  int         m_row  = 0;
  logic       m_busy = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  typedef struct {
    logic        v;
    logic [7:0]  p0, p1, p2;
    logic        ev, ed, eb;
    logic [71:0] ew;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [7:0] pix(int row, int k, int col);
    return 8'(50 * row + 10 * k + col);
  endfunction

  function automatic logic [71:0] win(int row, int start);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = pix(row, r, start + c);
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_col = 0;
    m_row = 0;
    m_busy = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("rst_window", window_o, '0);
    chk("rst_valid", 72'(valid_o), 72'(0));
    chk("rst_done", 72'(done_o), 72'(0));
    chk("rst_busy", 72'(busy_o), 72'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // Apply one cycle of input, advance one edge and compare against the model.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic        ev, ed;
    logic [71:0] ew;
    int          n;
    valid_i = v;
    row0_i = a;
    row1_i = b;
    row2_i = c;
    ev = 1'b0;
    ed = 1'b0;
    ew = '0;
    if (v) begin
      if (m_col == 0) begin
        q0.delete();
        q1.delete();
        q2.delete();
      end
      q0.push_back(a);
      q1.push_back(b);
      q2.push_back(c);
      m_busy = 1'b1;
      n = q0.size();
      if (n >= 3) begin
        ev = 1'b1;
        for (int k = 0; k < 3; k++) begin
          ew[8*k +: 8]     = q0[n-3+k];
          ew[8*(3+k) +: 8] = q1[n-3+k];
          ew[8*(6+k) +: 8] = q2[n-3+k];
        end
      end
      if (m_col == W - 1) begin
        m_col = 0;
        if (m_row == H - 3) begin
          ed = 1'b1;
          m_row = 0;
          m_busy = 1'b0;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
    chk("valid_o", 72'(valid_o), 72'(ev));
    chk("done_o", 72'(done_o), 72'(ed));
    chk("busy_o", 72'(busy_o), 72'(m_busy));
    if (ev) chk("window_o", window_o, ew);
    if (valid_o) n_win++;
    if (done_o) n_done++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, d0, acc;

    for (int row = 0; row < 2; row++)
      for (int col = 0; col < W; col++) begin
        int i;
        i = row * W + col;
        tbl[i].v  = 1'b1;
        tbl[i].p0 = pix(row, 0, col);
        tbl[i].p1 = pix(row, 1, col);
        tbl[i].p2 = pix(row, 2, col);
        tbl[i].ev = (col >= 2);
        tbl[i].ed = (row == 1 && col == W - 1);
        tbl[i].eb = !(row == 1 && col == W - 1);
        tbl[i].ew = (col >= 2) ? win(row, col - 2) : '0;
      end
    tbl[10] = '{v: 1'b0, p0: 8'h0, p1: 8'h0, p2: 8'h0, ev: 1'b0, ed: 1'b0, eb: 1'b0, ew: '0};

    #2;
    do_reset();

    // Contiguous frame from the table, including the row wrap and done pulse.
    for (int i = 0; i < 11; i++) begin
      valid_i = tbl[i].v;
      row0_i = tbl[i].p0;
      row1_i = tbl[i].p1;
      row2_i = tbl[i].p2;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 72'(valid_o), 72'(tbl[i].ev));
      chk($sformatf("tbl%0d_done", i), 72'(done_o), 72'(tbl[i].ed));
      chk($sformatf("tbl%0d_busy", i), 72'(busy_o), 72'(tbl[i].eb));
      if (tbl[i].ev) chk($sformatf("tbl%0d_window", i), window_o, tbl[i].ew);
      if (i == 2) chk("first_window", window_o, 72'h16_15_14_0c_0b_0a_02_01_00);
    end
    model_clear();

    // Gaps between every column.
    w0 = n_win;
    d0 = n_done;
    for (int row = 0; row < 2; row++)
      for (int col = 0; col < W; col++) begin
        drive(1'b1, pix(row, 0, col), pix(row, 1, col), pix(row, 2, col));
        drive(1'b0, 8'h0, 8'h0, 8'h0);
      end
    chk("gap_windows", 72'(n_win - w0), 72'(6));
    chk("gap_dones", 72'(n_done - d0), 72'(1));

    // Back-to-back frames: valid_i held high through the DONE cycle.
    w0 = n_win;
    d0 = n_done;
    for (int i = 0; i < 4 * W; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    drive(1'b0, 8'h0, 8'h0, 8'h0);
    chk("b2b_windows", 72'(n_win - w0), 72'(12));
    chk("b2b_dones", 72'(n_done - d0), 72'(2));

    // Mid-frame asynchronous reset discards the partial frame.
    for (int i = 0; i < 7; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    do_reset();
    w0 = n_win;
    d0 = n_done;
    for (int i = 0; i < 2; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    chk("post_rst_no_early_window", 72'(n_win - w0), 72'(0));
    for (int i = 0; i < 2 * W - 2; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    drive(1'b0, 8'h0, 8'h0, 8'h0);
    chk("post_rst_windows", 72'(n_win - w0), 72'(6));
    chk("post_rst_dones", 72'(n_done - d0), 72'(1));

    // Three frames with random gaps.
    w0 = n_win;
    d0 = n_done;
    acc = 0;
    while (acc < 3 * W * (H - 2)) begin
      logic v;
      v = ($urandom_range(0, 2) != 0);
      if (v) acc++;
      drive(v, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    drive(1'b0, 8'h0, 8'h0, 8'h0);
    chk("rand_windows", 72'(n_win - w0), 72'(18));
    chk("rand_dones", 72'(n_done - d0), 72'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
